// File: rtl/plusarg_cfg_pkg.sv
// Shared definitions for the boot-time configuration sequencer:
// state encoding and a ceil(log2) helper for sizing counters.
package plusarg_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned log2ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/plusarg_config_sequencer.sv
// Boot-time configuration sequencer: writes each enabled config word over a
// valid/ready register-write port, waits for its response and retries errors.
module plusarg_config_sequencer
  import plusarg_cfg_pkg::*;
#(
  parameter int unsigned          N_ENTRIES = 4,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          STRIDE    = 4,
  parameter int unsigned          MAX_RETRY = 3,
  localparam int unsigned         ERR_W     = (log2ceil(N_ENTRIES) > 0) ? log2ceil(N_ENTRIES) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_ENTRIES*DATA_W-1:0]   cfg_values,
  input  logic [N_ENTRIES-1:0]          cfg_enable,
  input  logic                          restart,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_W-1:0]             req_addr,
  output logic [DATA_W-1:0]             req_data,
  input  logic                          resp_valid,
  input  logic                          resp_error,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [ERR_W-1:0]              err_index
);

  localparam int unsigned IDX_W = log2ceil(N_ENTRIES + 1);
  localparam int unsigned RTY_W = (log2ceil(MAX_RETRY + 1) > 0) ? log2ceil(MAX_RETRY + 1) : 1;

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [RTY_W-1:0]   retry;
  logic               cur_en_c;
  logic [DATA_W-1:0]  cur_val_c;

  // Select the entry currently pointed to by idx (idx == N_ENTRIES selects nothing).
  always_comb begin
    cur_en_c  = 1'b0;
    cur_val_c = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_en_c  = cfg_enable[i];
        cur_val_c = cfg_values[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      retry     <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_SCAN;
          idx   <= '0;
          busy  <= 1'b1;
        end
        ST_SCAN: begin
          if (idx == IDX_W'(N_ENTRIES)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cur_en_c) begin
            req_addr  <= BASE_ADDR + ADDR_W'(idx) * ADDR_W'(STRIDE);
            req_data  <= cur_val_c;
            retry     <= '0;
            req_valid <= 1'b1;
            state     <= ST_REQ;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            if (!resp_error) begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SCAN;
            end else if (retry < RTY_W'(MAX_RETRY)) begin
              retry     <= retry + RTY_W'(1);
              req_valid <= 1'b1;
              state     <= ST_REQ;
            end else begin
              // Only the first exhausted entry is reported.
              if (!error) err_index <= ERR_W'(idx);
              error <= 1'b1;
              idx   <= idx + IDX_W'(1);
              state <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          if (restart) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plusarg_config_sequencer.sv
// Self-checking bench for plusarg_config_sequencer: directed scenarios plus
// randomized runs compared against a transaction-level expectation model.
module tb_plusarg_config_sequencer;
  import plusarg_cfg_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MR   = 3;
  localparam int unsigned STR  = 4;
  localparam int unsigned EW   = 2;
  localparam logic [AW-1:0] BASE = '0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N*DW-1:0]   cfg_values;
  logic [N-1:0]      cfg_enable;
  logic              restart = 1'b0;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic              resp_valid;
  logic              resp_error;
  logic              busy;
  logic              done;
  logic              error;
  logic [EW-1:0]     err_index;

  always #5 clock = ~clock;

  plusarg_config_sequencer #(
    .N_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .STRIDE(STR), .MAX_RETRY(MR)
  ) dut (
    .clock(clock), .reset(reset), .cfg_values(cfg_values), .cfg_enable(cfg_enable),
    .restart(restart), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .resp_valid(resp_valid), .resp_error(resp_error), .busy(busy),
    .done(done), .error(error), .err_index(err_index)
  );

  // Stimulus owned by the main sequence
  logic [DW-1:0] vals [N];
  logic [N-1:0]  en;
  int            budget [N];
  bit            slave_rst = 1'b1;
  bit            rand_ready = 1'b0;
  bit            scr_en = 1'b0;
  int            fixed_dly = 0;
  int            hold_init = 0;
  logic [AW-1:0] hold_addr = '0;

  // Owned by the slave model
  logic [DW-1:0] scr [N];
  wr_t           obs [$];
  int            used [N];

  int checks = 0;
  int errors = 0;

  always_comb begin
    for (int i = 0; i < N; i++) cfg_values[i*DW +: DW] = vals[i] ^ scr[i];
    cfg_enable = en;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Register-write slave: records accepted writes, answers each after a delay,
  // injects per-entry error budgets, and checks request stability while stalled.
  initial begin : slave
    int pend, pend_ent, hold_left;
    bit hs_prev, vprev;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    req_ready = 1'b0; resp_valid = 1'b0; resp_error = 1'b0;
    pend = -1; pend_ent = 0; hold_left = 0; hs_prev = 1'b0; vprev = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < N; i++) begin scr[i] = '0; used[i] = 0; end
    forever begin
      @(negedge clock);
      resp_valid = 1'b0;
      resp_error = 1'b0;
      if (slave_rst) begin
        obs.delete();
        for (int i = 0; i < N; i++) begin scr[i] = '0; used[i] = 0; end
        pend = -1; hs_prev = 1'b0; vprev = 1'b0; req_ready = 1'b0; hold_left = hold_init;
      end else begin
        if (vprev && !hs_prev) begin
          chk("valid_held", 64'(req_valid), 64'd1);
          chk("addr_stable", 64'(req_addr), 64'(pa));
          chk("data_stable", 64'(req_data), 64'(pd));
        end
        if (hs_prev) begin
          obs.push_back('{a: pa, d: pd});
          pend_ent = int'((pa - BASE) / STR);
          pend = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
          if (scr_en && pend_ent < N) scr[pend_ent] = $urandom;
        end
        if (pend == 0) begin
          resp_valid = 1'b1;
          if (pend_ent < N && used[pend_ent] < budget[pend_ent]) begin
            resp_error = 1'b1;
            used[pend_ent]++;
          end
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        if (req_valid && req_addr == hold_addr && hold_left > 0) begin
          req_ready = 1'b0;
          hold_left--;
        end else begin
          req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hs_prev = req_valid && req_ready;
        vprev = req_valid;
        pa = req_addr;
        pd = req_data;
      end
    end
  end

  // Expected transaction list from the sequencing rules.
  task automatic compare_run(input string tag);
    wr_t exp_q [$];
    bit exp_err;
    int exp_idx;
    int n;
    exp_err = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        n = (budget[i] > int'(MR)) ? int'(MR) + 1 : budget[i] + 1;
        for (int k = 0; k < n; k++) exp_q.push_back('{a: BASE + AW'(i * STR), d: vals[i]});
        if (budget[i] > int'(MR) && !exp_err) begin
          exp_err = 1'b1;
          exp_idx = i;
        end
      end
    end
    chk({tag, "_nwrites"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs[i].a), 64'(exp_q[i].a));
      chk({tag, "_data"}, 64'(obs[i].d), 64'(exp_q[i].d));
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_reqv"}, 64'(req_valid), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'(exp_err));
    chk({tag, "_errindex"}, 64'(err_index), 64'(exp_idx));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_reqv"}, 64'(req_valid), 64'd0);
    chk({tag, "_addr"}, 64'(req_addr), 64'd0);
    chk({tag, "_data"}, 64'(req_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_errindex"}, 64'(err_index), 64'd0);
  endtask

  // Hold reset for two cycles, then release just after a falling edge.
  task automatic start_seq();
    @(negedge clock); #1;
    reset = 1'b1; slave_rst = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0; slave_rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_finished"}, 64'(done), 64'd1);
  endtask

  task automatic set_cfg(input logic [N-1:0] e);
    en = e;
    for (int i = 0; i < N; i++) begin
      vals[i] = $urandom;
      budget[i] = 0;
    end
  endtask

  initial begin : main
    int n;
    set_cfg('0);

    // Reset state
    repeat (3) @(negedge clock);
    check_zero("reset");

    // All enabled, ready always high, responses one cycle after acceptance
    set_cfg(4'b1111);
    fixed_dly = 0;
    start_seq();
    @(negedge clock);
    chk("t1_scan_busy", 64'(busy), 64'd1);
    chk("t1_scan_reqv", 64'(req_valid), 64'd0);
    @(negedge clock);
    chk("t1_first_reqv", 64'(req_valid), 64'd1);
    chk("t1_first_addr", 64'(req_addr), 64'd0);
    chk("t1_first_data", 64'(req_data), 64'(vals[0]));
    wait_done("t1");
    compare_run("t1");

    // Sparse enables
    set_cfg(4'b1010);
    start_seq();
    wait_done("t2a");
    compare_run("t2a");

    // Nothing enabled: done rises on the sixth edge after release
    set_cfg(4'b0000);
    start_seq();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk("t2b_reqv", 64'(req_valid), 64'd0);
      if (k == 5) chk("t2b_done_early", 64'(done), 64'd0);
      if (k == 6) chk("t2b_done_time", 64'(done), 64'd1);
    end
    compare_run("t2b");

    // Slave stalls entry 1 for ten cycles
    set_cfg(4'b1111);
    hold_addr = BASE + AW'(STR);
    hold_init = 10;
    start_seq();
    wait_done("t3");
    compare_run("t3");
    hold_init = 0;

    // Entry 2 exhausts its retries, then restart clears the error
    set_cfg(4'b1111);
    budget[2] = 4;
    start_seq();
    wait_done("t4");
    compare_run("t4");
    @(negedge clock); #1;
    slave_rst = 1'b1;
    budget[2] = 0;
    @(negedge clock); #1;
    slave_rst = 1'b0;
    restart = 1'b1;
    @(negedge clock);
    chk("t4_restart_done", 64'(done), 64'd0);
    chk("t4_restart_error", 64'(error), 64'd0);
    chk("t4_restart_busy", 64'(busy), 64'd1);
    #1 restart = 1'b0;
    wait_done("t4r");
    compare_run("t4r");

    // Entry 0 recovers after two errors
    set_cfg(4'b1111);
    budget[0] = 2;
    start_seq();
    wait_done("t5");
    compare_run("t5");

    // Reset while waiting for the entry 1 response
    set_cfg(4'b1111);
    fixed_dly = 6;
    start_seq();
    n = 0;
    while (obs.size() < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t6_reached_wait", 64'(obs.size() >= 2), 64'd1);
    #1;
    reset = 1'b1; slave_rst = 1'b1;
    @(negedge clock);
    check_zero("t6_midreset");
    #1;
    reset = 1'b0; slave_rst = 1'b0; fixed_dly = 0;
    wait_done("t6");
    compare_run("t6");

    // Randomized runs: random enables, values, error budgets, stalls and delays;
    // captured words are scrambled after acceptance and a stray restart is pulsed.
    rand_ready = 1'b1;
    fixed_dly = -1;
    scr_en = 1'b1;
    for (int r = 0; r < 25; r++) begin
      set_cfg(N'($urandom));
      for (int i = 0; i < N; i++) budget[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      start_seq();
      repeat (2) @(negedge clock);
      #1 restart = 1'b1;
      @(negedge clock);
      #1 restart = 1'b0;
      wait_done("rnd");
      compare_run("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
